// File: rtl/stream_credit_tx.sv
// Credit-gated transmit end of a point-to-point link: forwards each accepted upstream
// beat as a registered one-cycle pulse, spending one credit per beat.
module stream_credit_tx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CREDITS    = 4,
  localparam int unsigned CNT_W     = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  stop_i,
  output logic                  tx_valid_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  input  logic                  crd_rtn_i,
  output logic [CNT_W-1:0]      credit_o,
  output logic                  idle_o,
  output logic                  err_o
);

  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS);

  logic [CNT_W-1:0]      credit_q;
  logic                  tx_valid_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  err_q;
  logic                  send;
  logic                  overflow;

  // Ready looks only at registered credit and stop_i, so a return this cycle
  // cannot be spent until the next one.
  assign s_ready_o = (credit_q != '0) && !stop_i;
  assign send      = s_valid_i && s_ready_o;
  assign overflow  = !send && crd_rtn_i && (credit_q == CREDIT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q   <= CREDIT_MAX;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      tx_valid_q <= send;
      if (send) begin
        tx_data_q <= s_data_i;
      end
      if (send && !crd_rtn_i) begin
        credit_q <= credit_q - CNT_W'(1);
      end else if (!send && crd_rtn_i && (credit_q != CREDIT_MAX)) begin
        credit_q <= credit_q + CNT_W'(1);
      end
      if (overflow) begin
        err_q <= 1'b1;
      end
    end
  end

  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
  assign credit_o   = credit_q;
  assign err_o      = err_q;
  assign idle_o     = (credit_q == CREDIT_MAX) && !tx_valid_q;

endmodule

// File: tb/tb_stream_credit_tx.sv
// Directed and random checks of stream_credit_tx with CREDITS=4 against hand-computed
// values and a behavioural model of the remote FIFO.
module tb_stream_credit_tx;

  localparam int unsigned DW    = 32;
  localparam int unsigned CR    = 4;
  localparam int unsigned CNT_W = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i;
  logic          stop_i;
  logic          tx_valid_o;
  logic [DW-1:0] tx_data_o;
  logic          crd_rtn_i;
  logic [CNT_W-1:0] credit_o;
  logic          idle_o;
  logic          err_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  stream_credit_tx #(.DATA_WIDTH(DW), .CREDITS(CR)) dut (
    .clk(clk), .rst(rst),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .stop_i(stop_i),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o),
    .crd_rtn_i(crd_rtn_i), .credit_o(credit_o),
    .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int            model_credit;
  logic          sent_prev;
  logic          exp_ready;
  logic [DW-1:0] exp_data;

  initial begin
    rst = 1'b1; s_valid_i = 1'b0; s_data_i = '0; stop_i = 1'b0; crd_rtn_i = 1'b0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_credit", 64'(credit_o), 64'(4));
    check("rst_txv", 64'(tx_valid_o), 64'(0));
    check("rst_txd", 64'(tx_data_o), 64'(0));
    check("rst_err", 64'(err_o), 64'(0));
    check("rst_idle", 64'(idle_o), 64'(1));
    check("rst_ready", 64'(s_ready_o), 64'(1));

    // 1: drain all credits with valid held high
    for (int i = 0; i < 6; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = DW'(32'h100 + i);
      #1 check("t1_ready", 64'(s_ready_o), 64'(i < 4));
      tick();
      check("t1_txv", 64'(tx_valid_o), 64'(i < 4));
      if (i < 4) check("t1_txd", 64'(tx_data_o), 64'(32'h100 + i));
      check("t1_credit", 64'(credit_o), 64'((i < 3) ? 3 - i : 0));
    end
    check("t1_idle", 64'(idle_o), 64'(0));

    // 2: returned credit usable only the following cycle
    s_valid_i = 1'b1; s_data_i = 32'hAA; crd_rtn_i = 1'b1;
    #1 check("t2_ready_n", 64'(s_ready_o), 64'(0));
    tick();
    crd_rtn_i = 1'b0;
    check("t2_credit1", 64'(credit_o), 64'(1));
    check("t2_txv_n", 64'(tx_valid_o), 64'(0));
    check("t2_ready_n1", 64'(s_ready_o), 64'(1));
    tick();
    s_valid_i = 1'b0;
    check("t2_txv", 64'(tx_valid_o), 64'(1));
    check("t2_txd", 64'(tx_data_o), 64'(32'hAA));
    check("t2_credit0", 64'(credit_o), 64'(0));
    tick();
    check("t2_txv_off", 64'(tx_valid_o), 64'(0));
    check("t2_txd_hold", 64'(tx_data_o), 64'(32'hAA));

    // 3: simultaneous send and return keeps credit steady
    crd_rtn_i = 1'b1;
    tick(); tick();
    check("t3_credit2", 64'(credit_o), 64'(2));
    for (int i = 0; i < 10; i++) begin
      s_valid_i = 1'b1; s_data_i = DW'(i);
      tick();
      check("t3_txv", 64'(tx_valid_o), 64'(1));
      check("t3_txd", 64'(tx_data_o), 64'(i));
      check("t3_credit", 64'(credit_o), 64'(2));
    end
    s_valid_i = 1'b0;

    // 4: send+return at full credit is legal; a bare return there is an overflow
    tick(); tick();
    crd_rtn_i = 1'b0;
    check("t4_credit4", 64'(credit_o), 64'(4));
    check("t4_idle", 64'(idle_o), 64'(1));
    check("t4_err0", 64'(err_o), 64'(0));
    s_valid_i = 1'b1; s_data_i = 32'h55; crd_rtn_i = 1'b1;
    tick();
    check("t4_full_swap_credit", 64'(credit_o), 64'(4));
    check("t4_full_swap_err", 64'(err_o), 64'(0));
    s_valid_i = 1'b0;
    tick();
    crd_rtn_i = 1'b0;
    check("t4_ovf_credit", 64'(credit_o), 64'(4));
    check("t4_ovf_err", 64'(err_o), 64'(1));
    tick(); tick();
    check("t4_err_sticky", 64'(err_o), 64'(1));

    // 6: reset mid-operation
    s_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data_i = DW'(32'h200 + i);
      tick();
    end
    s_valid_i = 1'b0;
    check("t6_pre_credit", 64'(credit_o), 64'(1));
    check("t6_pre_txv", 64'(tx_valid_o), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_txv", 64'(tx_valid_o), 64'(0));
    check("t6_credit", 64'(credit_o), 64'(4));
    check("t6_err", 64'(err_o), 64'(0));
    check("t6_idle", 64'(idle_o), 64'(1));

    // 5: stop blocks sends; in-flight beat still leaves; returns drain to idle
    s_valid_i = 1'b1;
    s_data_i = 32'h300; tick();
    s_data_i = 32'h301; tick();
    stop_i = 1'b1;
    #1 check("t5_ready", 64'(s_ready_o), 64'(0));
    check("t5_inflight_txv", 64'(tx_valid_o), 64'(1));
    check("t5_inflight_txd", 64'(tx_data_o), 64'(32'h301));
    tick();
    check("t5_nosend_txv", 64'(tx_valid_o), 64'(0));
    check("t5_credit2", 64'(credit_o), 64'(2));
    check("t5_idle0", 64'(idle_o), 64'(0));
    crd_rtn_i = 1'b1;
    tick(); tick();
    crd_rtn_i = 1'b0;
    check("t5_credit4", 64'(credit_o), 64'(4));
    check("t5_idle1", 64'(idle_o), 64'(1));
    check("t5_txv", 64'(tx_valid_o), 64'(0));
    stop_i = 1'b0; s_valid_i = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;

    // 7: random traffic against a remote FIFO model
    model_credit = CR;
    sent_prev = 1'b0;
    for (int c = 0; c < 300; c++) begin
      check("t7_txv", 64'(tx_valid_o), 64'(sent_prev));
      if (tx_valid_o) begin
        exp_data = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check("t7_order", 64'(tx_data_o), 64'(exp_data));
        fifo_q.push_back(tx_data_o);
        check("t7_fifo_room", 64'(fifo_q.size() <= CR), 64'(1));
      end
      crd_rtn_i = (fifo_q.size() != 0) && (c < 280) && ($urandom_range(0, 2) != 0);
      if (crd_rtn_i) void'(fifo_q.pop_front());
      s_valid_i = (c < 280) && ($urandom_range(0, 1) != 0);
      s_data_i  = $urandom;
      exp_ready = (model_credit != 0);
      #1 check("t7_ready", 64'(s_ready_o), 64'(exp_ready));
      sent_prev = s_valid_i && exp_ready;
      if (sent_prev) exp_q.push_back(s_data_i);
      model_credit = model_credit - int'(sent_prev) + int'(crd_rtn_i);
      tick();
    end
    crd_rtn_i = 1'b0; s_valid_i = 1'b0;
    for (int c = 0; c < 20 && fifo_q.size() != 0; c++) begin
      crd_rtn_i = 1'b1;
      void'(fifo_q.pop_front());
      tick();
    end
    crd_rtn_i = 1'b0;
    tick();
    check("t7_fifo_drained", 64'(fifo_q.size()), 64'(0));
    check("t7_credit", 64'(credit_o), 64'(4));
    check("t7_idle", 64'(idle_o), 64'(1));
    check("t7_err", 64'(err_o), 64'(0));
    check("t7_all_seen", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
